// File: rtl/bscan_switch_pkg.sv
// Shared constants and state type for the BSCAN port switch.
// The switch command is 16 bits: key byte in [15:8], port index in [7:0].
package bscan_switch_pkg;

    localparam int         CMD_WIDTH   = 16;
    localparam int         KEY_MSB     = 15;
    localparam int         KEY_LSB     = 8;
    localparam logic [7:0] IDX_RELEASE = 8'hFF;
    localparam logic [4:0] BITCNT_MAX  = 5'd31;

    typedef enum logic {
        IDLE,
        ROUTED
    } state_e;

endpackage

// File: rtl/bscan_switch_decode.sv
// Shadows every user-DR shift into a 16-bit register and flags a switch
// command when exactly 16 bits carrying the key were shifted before update.
module bscan_switch_decode
    import bscan_switch_pkg::*;
#(
    parameter logic [7:0] C_KEY = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_sel,
    input  logic       s_capture,
    input  logic       s_shift,
    input  logic       s_update,
    input  logic       s_tdi,
    output logic       cmd_valid,
    output logic [7:0] cmd_idx,
    output logic       shreg_lsb
);

    logic [CMD_WIDTH-1:0] shreg_q, shreg_d;
    logic [4:0]           bitcnt_q, bitcnt_d;

    // Capture takes priority over shift; the counter saturates so an
    // over-long shift can never alias to exactly 16 bits.
    always_comb begin
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        if (s_sel) begin
            if (s_capture) begin
                bitcnt_d = 5'd0;
            end else if (s_shift) begin
                shreg_d = {s_tdi, shreg_q[CMD_WIDTH-1:1]};
                if (bitcnt_q != BITCNT_MAX) begin
                    bitcnt_d = bitcnt_q + 5'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q  <= '0;
            bitcnt_q <= '0;
        end else begin
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
        end
    end

    assign cmd_valid = s_sel && s_update && !s_capture
                       && (bitcnt_q == 5'(CMD_WIDTH))
                       && (shreg_q[KEY_MSB:KEY_LSB] == C_KEY);
    assign cmd_idx   = shreg_q[KEY_LSB-1:0];
    assign shreg_lsb = shreg_q[0];

endmodule

// File: rtl/bscan_switch_ctrl.sv
// Routes one upstream BSCAN slave interface to a single selected downstream
// BSCAN master port, chosen by a keyed command shifted through the user DR.
module bscan_switch_ctrl
    import bscan_switch_pkg::*;
#(
    parameter int          C_NUM_PORTS = 4,
    parameter logic [7:0]  C_KEY       = 8'hA5,
    parameter logic [31:0] C_SWITCH_ID = 32'h0451_0000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_drck,
    input  logic                      s_reset,
    input  logic                      s_sel,
    input  logic                      s_capture,
    input  logic                      s_shift,
    input  logic                      s_update,
    input  logic                      s_tdi,
    input  logic                      s_runtest,
    input  logic                      s_tck,
    input  logic                      s_tms,
    input  logic                      s_bscanid_en,
    output logic                      s_tdo,
    output logic [31:0]               s_bscanid,
    output logic [C_NUM_PORTS-1:0]    m_drck,
    output logic [C_NUM_PORTS-1:0]    m_reset,
    output logic [C_NUM_PORTS-1:0]    m_sel,
    output logic [C_NUM_PORTS-1:0]    m_capture,
    output logic [C_NUM_PORTS-1:0]    m_shift,
    output logic [C_NUM_PORTS-1:0]    m_update,
    output logic [C_NUM_PORTS-1:0]    m_tdi,
    output logic [C_NUM_PORTS-1:0]    m_runtest,
    output logic [C_NUM_PORTS-1:0]    m_tck,
    output logic [C_NUM_PORTS-1:0]    m_tms,
    output logic [C_NUM_PORTS-1:0]    m_bscanid_en,
    input  logic [C_NUM_PORTS-1:0]    m_tdo,
    input  logic [32*C_NUM_PORTS-1:0] m_bscanid,
    output logic                      sel_valid,
    output logic [7:0]                sel_idx
);

    state_e          state_q, state_d;
    logic [7:0]      sel_idx_q, sel_idx_d;
    logic            cmd_valid;
    logic [7:0]      cmd_idx;
    logic            shreg_lsb;
    logic            route_en;
    logic [C_NUM_PORTS-1:0] port_hit;

    bscan_switch_decode #(
        .C_KEY(C_KEY)
    ) u_decode (
        .clk       (clk),
        .rst       (rst),
        .s_sel     (s_sel),
        .s_capture (s_capture),
        .s_shift   (s_shift),
        .s_update  (s_update),
        .s_tdi     (s_tdi),
        .cmd_valid (cmd_valid),
        .cmd_idx   (cmd_idx),
        .shreg_lsb (shreg_lsb)
    );

    // Selection changes take effect after the update edge, so the current
    // port still receives the update pulse of the command that deselects it.
    always_comb begin
        state_d   = state_q;
        sel_idx_d = sel_idx_q;
        if (cmd_valid) begin
            if (int'(cmd_idx) < C_NUM_PORTS) begin
                state_d   = ROUTED;
                sel_idx_d = cmd_idx;
            end else if (cmd_idx == IDX_RELEASE) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_idx_q <= sel_idx_d;
        end
    end

    assign route_en = (state_q == ROUTED) && !rst;

    always_comb begin
        for (int p = 0; p < C_NUM_PORTS; p++) begin
            port_hit[p] = route_en && (sel_idx_q == 8'(p));
        end
    end

    assign m_drck       = port_hit & {C_NUM_PORTS{s_drck}};
    assign m_reset      = port_hit & {C_NUM_PORTS{s_reset}};
    assign m_sel        = port_hit & {C_NUM_PORTS{s_sel}};
    assign m_capture    = port_hit & {C_NUM_PORTS{s_capture}};
    assign m_shift      = port_hit & {C_NUM_PORTS{s_shift}};
    assign m_update     = port_hit & {C_NUM_PORTS{s_update}};
    assign m_tdi        = port_hit & {C_NUM_PORTS{s_tdi}};
    assign m_runtest    = port_hit & {C_NUM_PORTS{s_runtest}};
    assign m_tck        = port_hit & {C_NUM_PORTS{s_tck}};
    assign m_tms        = port_hit & {C_NUM_PORTS{s_tms}};
    assign m_bscanid_en = port_hit & {C_NUM_PORTS{s_bscanid_en}};

    // port_hit is one-hot while routed, so OR-reduction acts as the return mux.
    always_comb begin
        s_tdo     = shreg_lsb;
        s_bscanid = C_SWITCH_ID;
        if (route_en) begin
            s_tdo     = |(m_tdo & port_hit);
            s_bscanid = '0;
            for (int p = 0; p < C_NUM_PORTS; p++) begin
                if (port_hit[p]) begin
                    s_bscanid = s_bscanid | m_bscanid[32*p +: 32];
                end
            end
        end
    end

    assign sel_valid = (state_q == ROUTED);
    assign sel_idx   = sel_idx_q;

endmodule

// File: tb/tb_bscan_switch_ctrl.sv
// Scoreboard bench for bscan_switch_ctrl: stimulus queues hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_bscan_switch_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_drck, s_reset, s_sel, s_capture, s_shift, s_update;
    logic         s_tdi, s_runtest, s_tck, s_tms, s_bscanid_en;
    logic         s_tdo;
    logic [31:0]  s_bscanid;
    logic [3:0]   m_drck, m_reset, m_sel, m_capture, m_shift, m_update;
    logic [3:0]   m_tdi, m_runtest, m_tck, m_tms, m_bscanid_en;
    logic [3:0]   m_tdo;
    logic [127:0] m_bscanid;
    logic         sel_valid;
    logic [7:0]   sel_idx;

    typedef struct {
        string       name;
        logic        selValid;
        logic [7:0]  selIdx;
        logic [3:0]  mSel;
        logic [3:0]  mUpdate;
        logic        mOr;
        logic        sTdo;
        logic [31:0] sBscanid;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    bscan_switch_ctrl #(
        .C_NUM_PORTS (4),
        .C_KEY       (8'hA5),
        .C_SWITCH_ID (32'h0451_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_drck       (s_drck),
        .s_reset      (s_reset),
        .s_sel        (s_sel),
        .s_capture    (s_capture),
        .s_shift      (s_shift),
        .s_update     (s_update),
        .s_tdi        (s_tdi),
        .s_runtest    (s_runtest),
        .s_tck        (s_tck),
        .s_tms        (s_tms),
        .s_bscanid_en (s_bscanid_en),
        .s_tdo        (s_tdo),
        .s_bscanid    (s_bscanid),
        .m_drck       (m_drck),
        .m_reset      (m_reset),
        .m_sel        (m_sel),
        .m_capture    (m_capture),
        .m_shift      (m_shift),
        .m_update     (m_update),
        .m_tdi        (m_tdi),
        .m_runtest    (m_runtest),
        .m_tck        (m_tck),
        .m_tms        (m_tms),
        .m_bscanid_en (m_bscanid_en),
        .m_tdo        (m_tdo),
        .m_bscanid    (m_bscanid),
        .sel_valid    (sel_valid),
        .sel_idx      (sel_idx)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input string n, input logic v, input logic [7:0] i,
                                input logic [3:0] ms, input logic [3:0] mu, input logic mo,
                                input logic t, input logic [31:0] b);
        exp_t e;
        e.name = n; e.selValid = v; e.selIdx = i; e.mSel = ms;
        e.mUpdate = mu; e.mOr = mo; e.sTdo = t; e.sBscanid = b;
        return e;
    endfunction

    task automatic cmpField(input string what, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", what, act, req);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        logic mOrAct;
        mOrAct = |{m_drck, m_reset, m_sel, m_capture, m_shift, m_update,
                   m_tdi, m_runtest, m_tck, m_tms, m_bscanid_en};
        cmpField({e.name, ".sel_valid"}, 32'(sel_valid), 32'(e.selValid));
        cmpField({e.name, ".sel_idx"},   32'(sel_idx),   32'(e.selIdx));
        cmpField({e.name, ".m_sel"},     32'(m_sel),     32'(e.mSel));
        cmpField({e.name, ".m_update"},  32'(m_update),  32'(e.mUpdate));
        cmpField({e.name, ".m_any"},     32'(mOrAct),    32'(e.mOr));
        cmpField({e.name, ".s_tdo"},     32'(s_tdo),     32'(e.sTdo));
        cmpField({e.name, ".s_bscanid"}, s_bscanid,      e.sBscanid);
    endtask

    // Monitor: compare the oldest expectation at each falling edge.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e);
        end
    end

    // Drive one cycle of upstream control, settled just after the rising edge.
    task automatic applyStimulus(input logic sel, input logic cap, input logic sh,
                                 input logic upd, input logic tdi);
        @(posedge clk);
        #1;
        s_sel = sel; s_capture = cap; s_shift = sh; s_update = upd; s_tdi = tdi;
    endtask

    task automatic shiftBits(input logic [63:0] val, input int n, input logic doCap);
        if (doCap) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, val[i]);
    endtask

    task automatic runCmd(input logic [63:0] val, input int n, input exp_t updExp, input exp_t postExp);
        shiftBits(val, n, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        expQ.push_back(updExp);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        expQ.push_back(postExp);
    endtask

    // Watchdog so a stuck run still ends with a reported failure.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b1;
        s_drck = 0; s_reset = 0; s_runtest = 0; s_tck = 0; s_tms = 0; s_bscanid_en = 0;
        s_sel = 1; s_capture = 0; s_shift = 1; s_update = 0; s_tdi = 1;
        m_tdo = 4'b0100;
        m_bscanid = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h1000_0000};

        @(posedge clk); #1;
        expQ.push_back(mk("reset", 0, 8'd0, 4'b0000, 4'b0000, 0, 0, 32'h0451_0000));
        @(posedge clk); #1;
        rst = 1'b0;
        s_sel = 0; s_shift = 0; s_tdi = 0;

        runCmd(64'hA502, 16,
               mk("sel2_upd",  0, 8'd0, 4'b0000, 4'b0000, 0, 0, 32'h0451_0000),
               mk("sel2_post", 1, 8'd2, 4'b0100, 4'b0000, 1, 1, 32'h2222_2222));

        applyStimulus(1, 0, 0, 0, 0);
        m_tdo = 4'b1011;
        expQ.push_back(mk("tdo_low",  1, 8'd2, 4'b0100, 4'b0000, 1, 0, 32'h2222_2222));
        applyStimulus(0, 0, 0, 0, 0);
        expQ.push_back(mk("sel_low",  1, 8'd2, 4'b0000, 4'b0000, 0, 0, 32'h2222_2222));
        applyStimulus(0, 0, 0, 0, 0);
        s_reset = 1'b1;
        expQ.push_back(mk("s_reset",  1, 8'd2, 4'b0000, 4'b0000, 1, 0, 32'h2222_2222));
        applyStimulus(0, 0, 0, 0, 0);
        s_reset = 1'b0;
        m_tdo = 4'b0100;

        runCmd(64'hA5FF, 16,
               mk("rel_upd",  1, 8'd2, 4'b0100, 4'b0100, 1, 1, 32'h2222_2222),
               mk("rel_post", 0, 8'd2, 4'b0000, 4'b0000, 0, 1, 32'h0451_0000));

        runCmd(64'h1_4A02, 17,
               mk("len17_upd",  0, 8'd2, 4'b0000, 4'b0000, 0, 1, 32'h0451_0000),
               mk("len17_post", 0, 8'd2, 4'b0000, 4'b0000, 0, 1, 32'h0451_0000));
        runCmd(64'h0000_00A5_0100_0000, 40,
               mk("len40_upd",  0, 8'd2, 4'b0000, 4'b0000, 0, 1, 32'h0451_0000),
               mk("len40_post", 0, 8'd2, 4'b0000, 4'b0000, 0, 1, 32'h0451_0000));
        runCmd(64'hA504, 16,
               mk("idx4_upd",  0, 8'd2, 4'b0000, 4'b0000, 0, 0, 32'h0451_0000),
               mk("idx4_post", 0, 8'd2, 4'b0000, 4'b0000, 0, 0, 32'h0451_0000));
        runCmd(64'h5A01, 16,
               mk("badkey_upd",  0, 8'd2, 4'b0000, 4'b0000, 0, 1, 32'h0451_0000),
               mk("badkey_post", 0, 8'd2, 4'b0000, 4'b0000, 0, 1, 32'h0451_0000));

        runCmd(64'hA501, 16,
               mk("sel1_upd",  0, 8'd2, 4'b0000, 4'b0000, 0, 1, 32'h0451_0000),
               mk("sel1_post", 1, 8'd1, 4'b0010, 4'b0000, 1, 0, 32'hDEAD_BEEF));

        // Capture together with update: no decode, counter cleared.
        shiftBits(64'hA503, 16, 1'b1);
        applyStimulus(1, 1, 0, 1, 0);
        expQ.push_back(mk("capupd",      1, 8'd1, 4'b0010, 4'b0010, 1, 0, 32'hDEAD_BEEF));
        applyStimulus(1, 0, 0, 0, 0);
        expQ.push_back(mk("capupd_post", 1, 8'd1, 4'b0010, 4'b0000, 1, 0, 32'hDEAD_BEEF));
        shiftBits(64'hA503, 16, 1'b0);
        applyStimulus(1, 0, 0, 1, 0);
        expQ.push_back(mk("sel3_upd",  1, 8'd1, 4'b0010, 4'b0010, 1, 0, 32'hDEAD_BEEF));
        applyStimulus(1, 0, 0, 0, 0);
        expQ.push_back(mk("sel3_post", 1, 8'd3, 4'b1000, 4'b0000, 1, 0, 32'h3333_3333));

        // Reset in the middle of a shift drops the selection.
        shiftBits(64'hFFFF, 5, 1'b1);
        rst = 1'b1;
        applyStimulus(1, 0, 1, 0, 1);
        expQ.push_back(mk("rst_mid",  0, 8'd0, 4'b0000, 4'b0000, 0, 0, 32'h0451_0000));
        @(posedge clk); #1;
        rst = 1'b0;
        s_sel = 0; s_shift = 0; s_tdi = 0;
        expQ.push_back(mk("rst_post", 0, 8'd0, 4'b0000, 4'b0000, 0, 0, 32'h0451_0000));

        repeat (3) @(posedge clk);
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bscan_switch_ctrl.md
Name: bscan_switch_ctrl

Overview:
- Shares one upstream BSCAN slave interface (S_BSCAN, from the BSCANE2/debug-bridge wirethrough) among C_NUM_PORTS downstream BSCAN master ports (M_BSCAN, one per debug core).
- Decodes a 16-bit switch command shifted through the user DR, holds the port selection, and routes control, data and ID signals to and from the selected port only.
- Runs in the JTAG clock domain; clk is driven from the same TCK net as s_tck.

Parameters:
- C_NUM_PORTS, 4, downstream ports (1..254).
- C_KEY, 8'hA5, command header byte.
- C_SWITCH_ID, 32'h0451_0000, BSCANID returned while no port is selected.

Ports:
- clk  in  1  clock, TCK-derived.
- rst  in  1  synchronous active-high reset.
- s_drck, s_reset, s_sel, s_capture, s_shift, s_update, s_tdi, s_runtest, s_tck, s_tms, s_bscanid_en  in  1 each  upstream BSCAN inputs.
- s_tdo  out  1  upstream TDO.
- s_bscanid  out  32  upstream BSCANID.
- m_drck, m_reset, m_sel, m_capture, m_shift, m_update, m_tdi, m_runtest, m_tck, m_tms, m_bscanid_en  out  C_NUM_PORTS each  per-port BSCAN outputs; bit i belongs to port i.
- m_tdo  in  C_NUM_PORTS  per-port TDO.
- m_bscanid  in  32*C_NUM_PORTS  per-port BSCANID; port i is bits [32i+31:32i].
- sel_valid  out  1  a port is currently routed.
- sel_idx  out  8  index of the routed port.

Behaviour:
- Reset: rst is sampled on the clk rising edge. Clears shreg[15:0], bitcnt, sel_valid=0, sel_idx=0, state=IDLE.
  - All m_* outputs are 0 whenever sel_valid=0 or rst=1.
- States:
  - IDLE: no port routed. s_tdo = shreg[0]. s_bscanid = C_SWITCH_ID.
  - ROUTED: port sel_idx routed.
- Routing in ROUTED, combinational:
  - For port p = sel_idx: m_*[p] = s_*; s_tdo = m_tdo[p]; s_bscanid = m_bscanid[p].
  - All other ports: every m_* bit is 0.
- Command shift register (active in both states):
  - s_sel & s_capture: bitcnt ← 0.
  - s_sel & s_shift: shreg ← {s_tdi, shreg[15:1]}. bitcnt ← bitcnt+1, saturating at 31 (5-bit counter).
- Command decode, on s_sel & s_update:
  - The command is valid only if bitcnt == 16 exactly and shreg[15:8] == C_KEY.
  - Invalid: no change to selection.
  - Valid with idx = shreg[7:0]:
    - idx < C_NUM_PORTS: sel_idx ← idx, sel_valid ← 1, state ROUTED.
    - idx == 8'hFF: sel_valid ← 0, state IDLE.
    - Any other idx: ignored.
  - The new selection drives routing from the next clk cycle. The update pulse itself still goes to the previously selected port, so that port sees a complete capture/shift/update sequence.
- In ROUTED, every shift is both forwarded to the selected port and shadowed into shreg. The downstream port never sees the switch command as special.
- Saturation: bitcnt stays at 31 for shifts longer than 31 bits, so any shift of more than 16 bits cannot form a valid command.
- Simultaneous s_capture and s_update: capture wins (bitcnt ← 0) and no decode happens.
- s_sel=0: shreg, bitcnt and selection hold. Routing continues, so the selected port sees m_sel=0.
- s_reset=1: routed to the selected port only. It does not affect the switch selection; only rst does.
- rst asserted mid-shift: selection is dropped immediately on that edge and all m_* outputs go to 0.

Decomposition:
- Package bscan_switch_pkg holds:
  - constants CMD_WIDTH=16, KEY_MSB=15, KEY_LSB=8, IDX_RELEASE=8'hFF;
  - the state enum {IDLE, ROUTED}.
- One sub-module, bscan_switch_decode: shreg, bitcnt and command validation. It outputs a one-cycle cmd_valid and cmd_idx.
- Routing muxes stay in the top module.

Test Plan:
- After rst: shift 16 bits of 16'hA502 with capture/update -> next cycle sel_valid=1, sel_idx=2, m_sel[2]=s_sel, m_sel[0,1,3]=0, s_tdo follows m_tdo[2].
- Routed to port 2: shift 16'hA5FF -> next cycle sel_valid=0, all m_*=0, s_bscanid=32'h0451_0000, s_tdo=shreg[0].
- Shift 17 bits ending in 16'hA501 -> no selection change (bitcnt≠16). Shift 31+ bits -> bitcnt saturates at 31, no decode.
- Shift 16'hA504 and 16'h5A01 with C_NUM_PORTS=4 -> both ignored, selection unchanged.
- Routed to port 1 with m_bscanid[1]=32'hDEAD_BEEF -> s_bscanid=32'hDEAD_BEEF. Assert rst mid-shift -> next edge sel_valid=0, all m_*=0.
- s_capture and s_update high together after a valid 16-bit key shift -> bitcnt=0, no selection change.
